// File: rtl/game_pkg.sv
// Shared definitions for the multi-target game controller: coordinate width,
// default screen geometry, FSM state type, LFSR taps and the spawn clamp.
package game_pkg;

   localparam int COORD_W   = 12;
   localparam int H_RES_DEF = 1280;
   localparam int V_RES_DEF = 1024;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      END  = 2'd2
   } game_state_t;

   // Folds a raw LFSR-derived coordinate back on screen so the whole box fits
   function automatic logic [COORD_W-1:0] spawn_clamp(
      input logic [COORD_W-1:0] raw,
      input logic [COORD_W-1:0] limit,
      input logic [COORD_W-1:0] wrap
   );
      return (raw >= limit) ? (raw - wrap) : raw;
   endfunction

endpackage

// File: rtl/target_slot.sv
// One target slot: position, valid flag, lifetime counter and hit-box compare.
// Optional build macro MOVING_TARGETS_EN adds the per-slot drift/reflect logic.
module target_slot
   import game_pkg::*;
#(
   parameter int TARGET_SIZE = 50,
   parameter int H_RES       = H_RES_DEF,
   parameter int V_RES       = V_RES_DEF,
   parameter int LIFE_W      = 32
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               run,
   input  logic               spawn,
   input  logic [COORD_W-1:0] spawn_x,
   input  logic [COORD_W-1:0] spawn_y,
   input  logic [LIFE_W-1:0]  spawn_life,
`ifdef MOVING_TARGETS_EN
   input  logic [1:0]         spawn_dir,
   input  logic               drift_tick,
`endif
   input  logic [COORD_W-1:0] marker_x,
   input  logic [COORD_W-1:0] marker_y,
   output logic [COORD_W-1:0] pos_x,
   output logic [COORD_W-1:0] pos_y,
   output logic               valid,
   output logic               in_box,
   output logic               expired
);

   localparam int EXT_W = COORD_W + 1;
   localparam logic [EXT_W-1:0] SIZE_V = EXT_W'(TARGET_SIZE);

   logic [LIFE_W-1:0] life_cnt;

`ifdef MOVING_TARGETS_EN
   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - TARGET_SIZE);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - TARGET_SIZE);
   logic dir_x;
   logic dir_y;
`endif

   // Slot state: clear beats spawn, spawn beats countdown (and drift)
   always_ff @(posedge clk) begin
      if (reset) begin
         valid    <= 1'b0;
         life_cnt <= '0;
         pos_x    <= '0;
         pos_y    <= '0;
`ifdef MOVING_TARGETS_EN
         dir_x    <= 1'b0;
         dir_y    <= 1'b0;
`endif
      end else if (clear) begin
         valid    <= 1'b0;
         life_cnt <= '0;
      end else if (spawn) begin
         valid    <= 1'b1;
         life_cnt <= spawn_life;
         pos_x    <= spawn_x;
         pos_y    <= spawn_y;
`ifdef MOVING_TARGETS_EN
         dir_x    <= spawn_dir[0];
         dir_y    <= spawn_dir[1];
`endif
      end else if (run && valid) begin
         if (life_cnt != '0) begin
            life_cnt <= life_cnt - LIFE_W'(1);
         end
`ifdef MOVING_TARGETS_EN
         if (drift_tick) begin
            if (dir_x) begin
               if (pos_x >= X_MAX - COORD_W'(1)) begin
                  pos_x <= X_MAX;
                  dir_x <= 1'b0;
               end else begin
                  pos_x <= pos_x + COORD_W'(1);
               end
            end else begin
               if (pos_x <= COORD_W'(1)) begin
                  pos_x <= '0;
                  dir_x <= 1'b1;
               end else begin
                  pos_x <= pos_x - COORD_W'(1);
               end
            end
            if (dir_y) begin
               if (pos_y >= Y_MAX - COORD_W'(1)) begin
                  pos_y <= Y_MAX;
                  dir_y <= 1'b0;
               end else begin
                  pos_y <= pos_y + COORD_W'(1);
               end
            end else begin
               if (pos_y <= COORD_W'(1)) begin
                  pos_y <= '0;
                  dir_y <= 1'b1;
               end else begin
                  pos_y <= pos_y - COORD_W'(1);
               end
            end
         end
`endif
      end
   end

   assign in_box = valid
                   && ({1'b0, marker_x} >= {1'b0, pos_x})
                   && ({1'b0, marker_x} <  ({1'b0, pos_x} + SIZE_V))
                   && ({1'b0, marker_y} >= {1'b0, pos_y})
                   && ({1'b0, marker_y} <  ({1'b0, pos_y} + SIZE_V));

   assign expired = valid && (life_cnt == '0);

endmodule

// File: rtl/multi_target_game_ctrl.sv
// Multi-target game controller: LFSR spawn positions, hit/expiry priority,
// score/miss counters and the IDLE/PLAY/END game FSM.
// Optional build macro MOVING_TARGETS_EN makes valid targets drift.
module multi_target_game_ctrl
   import game_pkg::*;
#(
   parameter int          N_TARGETS   = 3,
   parameter int          TARGET_SIZE = 50,
   parameter int          H_RES       = H_RES_DEF,
   parameter int          V_RES       = V_RES_DEF,
   parameter int          BASE_LIFE   = 108000000,
   parameter int          WIN_SCORE   = 15,
   parameter int          MAX_MISS    = 5,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
)(
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [2:0]                     level,
   input  logic                           trigger,
   input  logic [COORD_W-1:0]             marker_x,
   input  logic [COORD_W-1:0]             marker_y,
   output logic [COORD_W*N_TARGETS-1:0]   target_x,
   output logic [COORD_W*N_TARGETS-1:0]   target_y,
   output logic [N_TARGETS-1:0]           target_valid,
   output logic                           hit_ack,
   output logic                           miss_ack,
   output logic [7:0]                     score,
   output logic [3:0]                     misses,
   output logic                           game_end,
   output logic                           game_won
);

   localparam int          IDX_W  = 3;
   localparam logic [7:0]  WIN_V  = 8'(WIN_SCORE);
   localparam logic [3:0]  MISS_V = 4'(MAX_MISS);
   localparam logic [3:0]  NUM_V  = 4'(N_TARGETS);
   localparam logic [31:0] LIFE_V = 32'(BASE_LIFE);

   game_state_t          state, state_next;
   logic [15:0]          lfsr;
   logic [3:0]           stagger_idx;
   logic [7:0]           score_next;
   logic [3:0]           misses_next;
   logic                 won_next;
   logic                 start_game;
   logic                 hit_found, miss_found;
   logic                 do_hit, do_miss;
   logic [IDX_W-1:0]     hit_idx, miss_idx;
   logic [N_TARGETS-1:0] in_box, expired, spawn;
   logic                 clear_slots, run_slots;
   logic [COORD_W-1:0]   spawn_x, spawn_y;
   logic [31:0]          life_full, life_load;

   assign spawn_x = spawn_clamp({1'b0, lfsr[10:0]},
                                COORD_W'(H_RES - TARGET_SIZE), COORD_W'(1024));
   assign spawn_y = spawn_clamp({2'b00, lfsr[15:6]},
                                COORD_W'(V_RES - TARGET_SIZE), COORD_W'(512));

   // The counter holds remaining cycles minus one, so a slot is shown for
   // exactly BASE_LIFE >> level cycles before its expiry is serviced
   assign life_full = LIFE_V >> level;
   assign life_load = (life_full == 32'd0) ? 32'd0 : (life_full - 32'd1);

`ifdef MOVING_TARGETS_EN
   logic [19:0] drift_cnt;
   logic        drift_tick;

   // Free-running drift divider; tick once every 2^(20-level) play cycles
   always_ff @(posedge clk) begin
      if (reset || (state != PLAY)) begin
         drift_cnt <= '0;
      end else begin
         drift_cnt <= drift_cnt + 20'd1;
      end
   end

   assign drift_tick = ((drift_cnt & (20'hFFFFF >> level)) == (20'hFFFFF >> level));
`endif

   // Lowest-index in-box and lowest-index expired slot
   always_comb begin
      hit_found  = 1'b0;
      miss_found = 1'b0;
      hit_idx    = '0;
      miss_idx   = '0;
      for (int i = N_TARGETS - 1; i >= 0; i--) begin
         if (in_box[i]) begin
            hit_found = 1'b1;
            hit_idx   = IDX_W'(i);
         end
         if (expired[i]) begin
            miss_found = 1'b1;
            miss_idx   = IDX_W'(i);
         end
      end
   end

   // An expired slot that is also being hit counts as a hit only
   assign do_hit  = (state == PLAY) && trigger && hit_found;
   assign do_miss = (state == PLAY) && miss_found && !(do_hit && (miss_idx == hit_idx));

   // Next state, counters and win flag; win is checked before loss
   always_comb begin
      state_next  = state;
      start_game  = 1'b0;
      score_next  = score;
      misses_next = misses;
      won_next    = game_won;
      case (state)
         IDLE, END: begin
            if (start) begin
               state_next  = PLAY;
               start_game  = 1'b1;
               score_next  = 8'd0;
               misses_next = 4'd0;
               won_next    = 1'b0;
            end
         end
         PLAY: begin
            if (do_hit && (score != 8'hFF)) begin
               score_next = score + 8'd1;
            end
            if (do_miss && (misses != 4'hF)) begin
               misses_next = misses + 4'd1;
            end
            if (score_next >= WIN_V) begin
               state_next = END;
               won_next   = 1'b1;
            end else if (misses_next >= MISS_V) begin
               state_next = END;
               won_next   = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Per-slot spawn requests: game start, staggered fill, hit or expiry
   always_comb begin
      spawn = '0;
      for (int i = 0; i < N_TARGETS; i++) begin
         spawn[i] = (start_game && (i == 0))
                    || ((state == PLAY) && (stagger_idx == 4'(i)))
                    || (do_hit  && (hit_idx  == IDX_W'(i)))
                    || (do_miss && (miss_idx == IDX_W'(i)));
      end
   end

   assign clear_slots = (state_next != PLAY);
   assign run_slots   = (state == PLAY);
   assign game_end    = (state == END);

   // State register, LFSR, counters and the one-cycle ack pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         lfsr        <= LFSR_SEED;
         stagger_idx <= 4'd0;
         score       <= 8'd0;
         misses      <= 4'd0;
         game_won    <= 1'b0;
         hit_ack     <= 1'b0;
         miss_ack    <= 1'b0;
      end else begin
         state    <= state_next;
         lfsr     <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
         score    <= score_next;
         misses   <= misses_next;
         game_won <= won_next;
         hit_ack  <= do_hit;
         miss_ack <= do_miss;
         if (start_game) begin
            stagger_idx <= 4'd1;
         end else if ((state == PLAY) && (stagger_idx < NUM_V)) begin
            stagger_idx <= stagger_idx + 4'd1;
         end
      end
   end

   for (genvar g = 0; g < N_TARGETS; g++) begin : g_slot
      target_slot #(
         .TARGET_SIZE (TARGET_SIZE),
         .H_RES       (H_RES),
         .V_RES       (V_RES),
         .LIFE_W      (32)
      ) u_slot (
         .clk        (clk),
         .reset      (reset),
         .clear      (clear_slots),
         .run        (run_slots),
         .spawn      (spawn[g]),
         .spawn_x    (spawn_x),
         .spawn_y    (spawn_y),
         .spawn_life (life_load),
`ifdef MOVING_TARGETS_EN
         .spawn_dir  (lfsr[1:0]),
         .drift_tick (drift_tick),
`endif
         .marker_x   (marker_x),
         .marker_y   (marker_y),
         .pos_x      (target_x[COORD_W*g +: COORD_W]),
         .pos_y      (target_y[COORD_W*g +: COORD_W]),
         .valid      (target_valid[g]),
         .in_box     (in_box[g]),
         .expired    (expired[g])
      );
   end

endmodule
